// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM leg: centre-aligned duty compare, dead-time insertion between gates, sticky fault trip.
// Gate turns off 2 cycles after the compare crossing; the opposite gate turns on DEADTIME cycles later.
module pwm_deadtime_gen #(
    parameter int WIDTH    = 10,
    parameter int DT_WIDTH = 6,
    parameter int DEADTIME = 8
) (
    input  logic             i_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_wr,
    input  logic             en,
    input  logic             fault_in,
    input  logic             fault_clr,
    output logic             pwm_h,
    output logic             pwm_l,
    output logic             fault,
    output logic             period_start
);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_DEAD = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    localparam logic [DT_WIDTH-1:0] DT_LAST = DT_WIDTH'(DEADTIME - 1);

    logic [WIDTH-1:0]    value_q;
    logic [WIDTH-1:0]    pending_q;
    logic [WIDTH-1:0]    active_q;
    logic                raw_q;
    logic                fault_q;
    logic                period_start_q;
    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic [DT_WIDTH-1:0] cnt_q;
    logic [DT_WIDTH-1:0] cnt_d;
    logic                target_q;
    logic                target_d;
    logic                pwm_h_q;
    logic                pwm_l_q;

    logic valley;
    logic trip;
    logic raw_d;
    logic fault_d;

    // value_q resets to all-ones so the first zero after reset is treated as a valley
    assign valley = (value == '0) && (value_q != '0);
    assign trip   = !en || fault_q || fault_in;
    assign raw_d  = (value < active_q) || (active_q == '1);

    always_comb begin
        fault_d = fault_q;
        if (fault_in) begin
            fault_d = 1'b1;
        end else if (fault_clr) begin
            fault_d = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        if (trip) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d  = ST_DEAD;
                    target_d = raw_q;
                    cnt_d    = '0;
                end
                ST_DEAD: begin
                    // a compare change during dead-time restarts the full interval
                    if (raw_q != target_q) begin
                        target_d = raw_q;
                        cnt_d    = '0;
                    end else if (cnt_q == DT_LAST) begin
                        state_d = target_q ? ST_HIGH : ST_LOW;
                    end else begin
                        cnt_d = cnt_q + DT_WIDTH'(1);
                    end
                end
                ST_HIGH: begin
                    if (!raw_q) begin
                        state_d  = ST_DEAD;
                        target_d = 1'b0;
                        cnt_d    = '0;
                    end
                end
                default: begin
                    if (raw_q) begin
                        state_d  = ST_DEAD;
                        target_d = 1'b1;
                        cnt_d    = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!rst_n) begin
            value_q        <= '1;
            pending_q      <= '0;
            active_q       <= '0;
            raw_q          <= 1'b0;
            fault_q        <= 1'b0;
            period_start_q <= 1'b0;
            state_q        <= ST_OFF;
            cnt_q          <= '0;
            target_q       <= 1'b0;
            pwm_h_q        <= 1'b0;
            pwm_l_q        <= 1'b0;
        end else begin
            value_q        <= value;
            raw_q          <= raw_d;
            fault_q        <= fault_d;
            period_start_q <= valley;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            target_q       <= target_d;
            pwm_h_q        <= (state_d == ST_HIGH);
            pwm_l_q        <= (state_d == ST_LOW);
            if (duty_wr) begin
                pending_q <= duty_in;
            end
            // a same-cycle write lands in pending after active has taken the old word
            if (valley) begin
                active_q <= pending_q;
            end
        end
    end

    assign pwm_h        = pwm_h_q;
    assign pwm_l        = pwm_l_q;
    assign fault        = fault_q;
    assign period_start = period_start_q;

endmodule

// File: doc/pwm_deadtime_gen.md
# pwm_deadtime_gen

Complementary PWM output stage driven by the center-aligned triangle counter. It compares the triangle `value` against a duty word that is double-buffered and updated only at the triangle valley. It then produces a high-side/low-side gate pair with programmable dead-time and a sticky fault shutdown. It sits directly downstream of the up/down counter and drives the gate-driver pins, one instance per half-bridge leg.

## Interface
- `WIDTH`, 10: width of the triangle value and of the duty word.
- `DT_WIDTH`, 6: width of the dead-time count.
- `DEADTIME`, 8: dead-time in clock cycles; legal range 1 to 2^DT_WIDTH-1.

- `i_clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `value`  in  WIDTH  triangle from the center-aligned counter: 0 up to 2^WIDTH-1, back down to 0; peak and valley are each held for 2 cycles.
- `duty_in`  in  WIDTH  new duty word.
- `duty_wr`  in  1  one-cycle strobe; captures `duty_in` into the pending register.
- `en`  in  1  output enable; 0 forces both gates low.
- `fault_in`  in  1  external trip, level.
- `fault_clr`  in  1  clears the latched fault; honoured only while `fault_in`=0.
- `pwm_h`  out  1  high-side gate, registered.
- `pwm_l`  out  1  low-side gate, registered.
- `fault`  out  1  latched fault status, registered.
- `period_start`  out  1  one-cycle pulse on the valley event, registered.

## Operation
- Duty path:
  - `duty_wr`=1 loads `pending` with `duty_in`.
  - On the valley event, `active` loads `pending`.
  - If `duty_wr` and the valley event fall in the same cycle, `active` takes the old `pending` and the new word waits for the next valley.
- Valley event: `value`==0 and `value_q`!=0, where `value_q` is `value` registered. `value_q` resets to all-ones, so the first zero after reset counts as a valley. The event fires once per period, on the first of the two zero cycles. `period_start` is this event registered.
- Compare: `raw_q` <= (`value` < `active`) OR (`active`==2^WIDTH-1).
  - `active`=0 gives a 0% duty cycle.
  - All-ones gives a 100% duty cycle.
  - 1 means high side requested, 0 means low side.
- Fault handling:
  - `fault_in`=1 sets `fault`, which is sticky.
  - `fault_clr`=1 with `fault_in`=0 clears it.
  - If `fault_in` and `fault_clr` are both 1, `fault` stays set.
- State machine (state register plus dead-time counter `cnt`):
  - OFF: both gates low. Exits to DEAD with target=`raw_q`, `cnt`=0, when `en`=1 and `fault`=0.
  - DEAD: both gates low.
    - If `raw_q`!=target, target <= `raw_q` and `cnt` <= 0 (the dead-time restarts).
    - Else, if `cnt`==DEADTIME-1, go to HIGH (target 1) or LOW (target 0).
    - Else, `cnt` increments.
  - HIGH: `pwm_h`=1. When `raw_q`=0, go to DEAD with target 0 and `cnt`=0.
  - LOW: `pwm_l`=1. When `raw_q`=1, go to DEAD with target 1 and `cnt`=0.
  - From any state, `en`=0 or (`fault`=1, or `fault_in`=1 in this cycle) goes to OFF. This has priority over every other transition.
- Invariant: `pwm_h` and `pwm_l` are never both 1 in any cycle. Any state change between HIGH and LOW passes through at least DEADTIME cycles of DEAD.

## Timing
- Reset, sampled at an edge while `rst_n`=0, gives:
  - state OFF, `cnt`=0;
  - `pending`=0, `active`=0, `raw_q`=0;
  - `value_q` all-ones;
  - `pwm_h`=0, `pwm_l`=0, `fault`=0, `period_start`=0.
- Reset mid-operation: both gates are low after that edge. There is no drain or dead-time sequence.
- Compare latency: a `value` change at edge k is reflected in `raw_q` at edge k+1.
- Gate-off latency: the gate turns off at edge k+2, counted from the edge where `value` crossed `active`.
- Gate-on latency: the opposite gate turns on at edge k+2+DEADTIME.
- Fault latency: `fault_in` sampled at edge k gives both gates low and `fault`=1 after edge k.
- Re-enable: after `fault_clr` or `en` rising, the gates stay low for 1 cycle in OFF plus DEADTIME cycles in DEAD before either gate turns on.
- Duty update: a write takes effect on the compare no earlier than the next valley event. `raw_q` reflects the new `active` one cycle after the valley.

## Test plan
- WIDTH=4, DEADTIME=3, `active`=8, rising ramp with `value`=8 at edge k:
  - `pwm_h` falls at k+2;
  - `pwm_l` rises at k+5;
  - on the falling slope, `pwm_l` falls and `pwm_h` rises 3 cycles later;
  - never both high.
- `duty_wr` with 5 mid-period: the compare still uses the old duty until the valley. After the valley, the high width is 10 cycles minus dead-time, and `period_start` pulses once per 32-cycle period.
- `duty_wr` in the same cycle as the valley: `active` keeps the old `pending`, and the new duty is applied one period later.
- `active`=0 gives `pwm_h`=0 for the whole period. `active`=15 gives `pwm_h`=1 continuously after the first dead-time, including across the 2-cycle peak.
- Fault sequence:
  - `fault_in` pulse while HIGH: both gates low and `fault`=1 the next cycle.
  - `fault_clr` with `fault_in`=1: `fault` stays 1.
  - `fault_clr` with `fault_in`=0: `fault` clears, then 1 + 3 cycles with both gates low before a gate turns on.
- Dead-time restart: with DEADTIME=8, a `raw_q` glitch of 0 then 1 within 4 cycles keeps both gates low. The counter restarts, so both gates stay low for 8 full cycles after the last `raw_q` change.
